// File: rtl/gp_eval_pkg.sv
// Shared definitions for the GP truth-table evaluator: FSM state encoding and
// helpers that derive table and score widths from the candidate input count.
package gp_eval_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_DONE
  } eval_state_e;

  // Largest settle time the settle counter is sized for.
  localparam int MAX_SETTLE = 15;

  function automatic int calc_rows(input int n_in);
    return 1 << n_in;
  endfunction

  function automatic int calc_fit_w(input int n_in);
    return n_in + 1;
  endfunction

endpackage

// File: rtl/tt_fitness_eval_if.sv
// Request/result bus between the GP controller (master) and the truth-table
// evaluator (slave).
interface tt_fitness_eval_if #(
  parameter int N_IN = 4
);
  import gp_eval_pkg::*;

  localparam int ROWS  = calc_rows(N_IN);
  localparam int FIT_W = calc_fit_w(N_IN);

  logic             start;
  logic [ROWS-1:0]  target;
  logic             busy;
  logic             done;
  logic [ROWS-1:0]  truth_table;
  logic [FIT_W-1:0] fitness;
  logic             perfect;

  modport master (
    output start, target,
    input  busy, done, truth_table, fitness, perfect
  );

  modport slave (
    input  start, target,
    output busy, done, truth_table, fitness, perfect
  );

endinterface

// File: rtl/tt_row_sequencer.sv
// Row and settle counters for the evaluator scan. The row counter steps once
// per sampled row and never wraps; the settle counter times the DRIVE phase.
module tt_row_sequencer
  import gp_eval_pkg::*;
#(
  parameter int N_IN          = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            settle_en,
  input  logic            advance,
  output logic [N_IN-1:0] row,
  output logic            settle_done,
  output logic            last_row
);

  localparam int SETTLE_W = $clog2(MAX_SETTLE + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  logic [SETTLE_W-1:0] settle_cnt;

  // NOTE: registers are updated with <= so every flop samples pre-edge values;
  // blocking assignments here would make the result depend on statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      row        <= '0;
      settle_cnt <= '0;
    end else begin
      if (clear) begin
        row <= '0;
      end else if (advance) begin
        row <= row + 1'b1;
      end

      // Parks at SETTLE_LAST during SAMPLE until the next row clears it.
      if (clear || advance) begin
        settle_cnt <= '0;
      end else if (settle_en && !settle_done) begin
        settle_cnt <= settle_cnt + 1'b1;
      end
    end
  end

  assign settle_done = (settle_cnt == SETTLE_LAST);
  assign last_row    = &row;

endmodule

// File: rtl/tt_fitness_eval.sv
// Sequential truth-table evaluator: scans all input rows of a combinational
// candidate, records its output and scores it against a latched target table.
module tt_fitness_eval
  import gp_eval_pkg::*;
#(
  parameter int N_IN          = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  tt_fitness_eval_if.slave   bus,
  output logic [N_IN-1:0]    stim,
  input  logic               e
);

  localparam int ROWS  = calc_rows(N_IN);
  localparam int FIT_W = calc_fit_w(N_IN);

  eval_state_e      state, state_next;
  logic             accept, settle_en, advance, finish;

  logic [N_IN-1:0]  row;
  logic             settle_done, last_row;

  logic [ROWS-1:0]  target_q, table_q, table_upd;
  logic [FIT_W-1:0] match_q, match_upd;
  logic             hit;

  logic [ROWS-1:0]  truth_table_q;
  logic [FIT_W-1:0] fitness_q;
  logic             perfect_q, done_q;

  tt_row_sequencer #(
    .N_IN          (N_IN),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_seq (
    .clk         (clk),
    .rst         (rst),
    .clear       (accept),
    .settle_en   (settle_en),
    .advance     (advance),
    .row         (row),
    .settle_done (settle_done),
    .last_row    (last_row)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    settle_en  = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        settle_en = 1'b1;
        if (settle_done) state_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (last_row) begin
          finish     = 1'b1;
          state_next = ST_DONE;
        end else begin
          advance    = 1'b1;
          state_next = ST_DRIVE;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Working table and score including the row being sampled this cycle, so the
  // final row can be folded straight into the result registers.
  always_comb begin
    hit            = (e == target_q[row]);
    table_upd      = table_q;
    table_upd[row] = e;
    match_upd      = match_q + FIT_W'(hit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target_q <= '0;
      table_q  <= '0;
      match_q  <= '0;
    end else if (accept) begin
      target_q <= bus.target;
      table_q  <= '0;
      match_q  <= '0;
    end else if (state == ST_SAMPLE) begin
      table_q  <= table_upd;
      match_q  <= match_upd;
    end
  end

  // Results load on the last sample edge so they appear together with done.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q        <= 1'b0;
      truth_table_q <= '0;
      fitness_q     <= '0;
      perfect_q     <= 1'b0;
    end else begin
      done_q <= finish;
      if (finish) begin
        truth_table_q <= table_upd;
        fitness_q     <= match_upd;
        perfect_q     <= (match_upd == FIT_W'(ROWS));
      end
    end
  end

  assign stim            = (state == ST_DRIVE || state == ST_SAMPLE) ? row : '0;
  assign bus.busy        = (state != ST_IDLE);
  assign bus.done        = done_q;
  assign bus.truth_table = truth_table_q;
  assign bus.fitness     = fitness_q;
  assign bus.perfect     = perfect_q;

endmodule

// File: tb/tb_tt_fitness_eval.sv
// Directed bench for tt_fitness_eval with a candidate e = (stim == 4'b1101),
// one instance at SETTLE_CYCLES=1 and one at SETTLE_CYCLES=3.
module tb_tt_fitness_eval;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tt_fitness_eval_if #(.N_IN(4)) bus_a ();
  tt_fitness_eval_if #(.N_IN(4)) bus_b ();

  logic [3:0] stim_a, stim_b;
  logic       e_a, e_b;

  assign e_a = (stim_a == 4'b1101);
  assign e_b = (stim_b == 4'b1101);

  tt_fitness_eval #(.N_IN(4), .SETTLE_CYCLES(1)) dut_a (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus_a),
    .stim (stim_a),
    .e    (e_a)
  );

  tt_fitness_eval #(.N_IN(4), .SETTLE_CYCLES(3)) dut_b (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus_b),
    .stim (stim_b),
    .e    (e_b)
  );

  int checks     = 0;
  int errors     = 0;
  int cycle      = 0;
  int done_cnt_a = 0;
  int t_a        = 0;

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (bus_a.done === 1'b1) done_cnt_a <= done_cnt_a + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_a(input logic [15:0] tgt);
    @(negedge clk);
    bus_a.target = tgt;
    bus_a.start  = 1'b1;
    t_a          = cycle;
    @(negedge clk);
    bus_a.start  = 1'b0;
  endtask

  task automatic wait_done_a(output int lat);
    int n;
    n = 0;
    while (bus_a.done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    lat = cycle - t_a;
    check("done_seen_a", {31'd0, bus_a.done}, 32'd1);
  endtask

  task automatic wait_stim_a(input logic [3:0] v);
    int n;
    n = 0;
    while (stim_a !== v && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_stim_a", {28'd0, stim_a}, {28'd0, v});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int d0;
    int bad;
    int t_b;

    rst          = 1'b1;
    bus_a.start  = 1'b0;
    bus_a.target = '0;
    bus_b.start  = 1'b0;
    bus_b.target = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_stim",    {28'd0, stim_a},            32'd0);
    check("rst_busy",    {31'd0, bus_a.busy},        32'd0);
    check("rst_done",    {31'd0, bus_a.done},        32'd0);
    check("rst_tt",      {16'd0, bus_a.truth_table}, 32'd0);
    check("rst_fitness", {27'd0, bus_a.fitness},     32'd0);
    check("rst_perfect", {31'd0, bus_a.perfect},     32'd0);

    // Exact-match target, latency 1 + 16*2 = 33
    start_a(16'h2000);
    check("busy_after_start", {31'd0, bus_a.busy}, 32'd1);
    wait_done_a(lat);
    check("lat_s1",       lat,                         32'd33);
    check("tt_2000",      {16'd0, bus_a.truth_table},  32'h2000);
    check("fit_2000",     {27'd0, bus_a.fitness},      32'd16);
    check("perf_2000",    {31'd0, bus_a.perfect},      32'd1);
    check("busy_in_done", {31'd0, bus_a.busy},         32'd1);

    // start during the DONE cycle is ignored
    bus_a.target = 16'h0000;
    bus_a.start  = 1'b1;
    @(negedge clk);
    bus_a.start  = 1'b0;
    check("done_start_busy", {31'd0, bus_a.busy},    32'd0);
    check("done_start_done", {31'd0, bus_a.done},    32'd0);
    check("done_start_fit",  {27'd0, bus_a.fitness}, 32'd16);

    // All-zero and all-one targets
    start_a(16'h0000);
    wait_done_a(lat);
    check("tt_0000",   {16'd0, bus_a.truth_table}, 32'h2000);
    check("fit_0000",  {27'd0, bus_a.fitness},     32'd15);
    check("perf_0000", {31'd0, bus_a.perfect},     32'd0);
    start_a(16'hFFFF);
    wait_done_a(lat);
    check("fit_ffff",  {27'd0, bus_a.fitness},     32'd1);
    check("perf_ffff", {31'd0, bus_a.perfect},     32'd0);

    // Back-to-back evaluations; results hold until the second done
    start_a(16'h2000);
    wait_done_a(lat);
    check("b2b_fit1",  {27'd0, bus_a.fitness}, 32'd16);
    check("b2b_perf1", {31'd0, bus_a.perfect}, 32'd1);
    start_a(16'h0001);
    check("b2b_busy2", {31'd0, bus_a.busy},    32'd1);
    wait_stim_a(4'd8);
    check("hold_fit",  {27'd0, bus_a.fitness},     32'd16);
    check("hold_perf", {31'd0, bus_a.perfect},     32'd1);
    check("hold_tt",   {16'd0, bus_a.truth_table}, 32'h2000);
    wait_done_a(lat);
    check("b2b_lat2",  lat,                         32'd33);
    check("b2b_fit2",  {27'd0, bus_a.fitness},      32'd14);
    check("b2b_perf2", {31'd0, bus_a.perfect},      32'd0);
    check("b2b_tt2",   {16'd0, bus_a.truth_table},  32'h2000);

    // Reset mid-scan aborts without done
    start_a(16'h2000);
    wait_stim_a(4'd7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_stim",    {28'd0, stim_a},            32'd0);
    check("abort_busy",    {31'd0, bus_a.busy},        32'd0);
    check("abort_done",    {31'd0, bus_a.done},        32'd0);
    check("abort_tt",      {16'd0, bus_a.truth_table}, 32'd0);
    check("abort_fitness", {27'd0, bus_a.fitness},     32'd0);
    check("abort_perfect", {31'd0, bus_a.perfect},     32'd0);
    d0 = done_cnt_a;
    repeat (40) @(negedge clk);
    check("abort_no_done", done_cnt_a - d0, 32'd0);
    start_a(16'h2000);
    wait_done_a(lat);
    check("after_abort_fit", {27'd0, bus_a.fitness},     32'd16);
    check("after_abort_tt",  {16'd0, bus_a.truth_table}, 32'h2000);

    // start and target change mid-scan are ignored
    @(negedge clk);
    d0 = done_cnt_a;
    start_a(16'h2000);
    wait_stim_a(4'd5);
    bus_a.target = 16'h0000;
    bus_a.start  = 1'b1;
    @(negedge clk);
    bus_a.start  = 1'b0;
    wait_done_a(lat);
    check("midstart_lat",  lat,                     32'd33);
    check("midstart_fit",  {27'd0, bus_a.fitness},  32'd16);
    check("midstart_perf", {31'd0, bus_a.perfect},  32'd1);
    repeat (3) @(negedge clk);
    check("midstart_one_done", done_cnt_a - d0, 32'd1);

    // SETTLE_CYCLES=3: each row held 4 cycles, done after 65
    @(negedge clk);
    bus_b.target = 16'h2000;
    bus_b.start  = 1'b1;
    t_b          = cycle;
    @(negedge clk);
    bus_b.start  = 1'b0;
    bad = 0;
    for (int c = 1; c <= 64; c++) begin
      if (stim_b !== 4'((c - 1) / 4)) bad++;
      if (bus_b.done !== 1'b0) bad++;
      @(negedge clk);
    end
    check("s3_stim_seq", bad,                         32'd0);
    check("s3_done",     {31'd0, bus_b.done},         32'd1);
    check("s3_lat",      cycle - t_b,                 32'd65);
    check("s3_fit",      {27'd0, bus_b.fitness},      32'd16);
    check("s3_tt",       {16'd0, bus_b.truth_table},  32'h2000);
    check("s3_perf",     {31'd0, bus_b.perfect},      32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
